// File: rtl/wb_reg_pkg.sv
// Shared definitions for the Wishbone register slave: register indices,
// FSM states, bit positions and the byte-lane merge helper.
package wb_reg_pkg;

  localparam logic [2:0] REG_ID      = 3'd0;
  localparam logic [2:0] REG_CTRL    = 3'd1;
  localparam logic [2:0] REG_LEDS    = 3'd2;
  localparam logic [2:0] REG_SCRATCH = 3'd3;
  localparam logic [2:0] REG_COUNTER = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;

  localparam int CTRL_IRQ_EN_BIT = 0;
  localparam int STATUS_BTN_BIT  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) begin
        res[8*k +: 8] = new_val[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_val[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a
// rising-edge detector producing a one-cycle pulse.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise
);

  logic sync1_q, sync2_q, prev_q;

  // synchronizer chain plus delayed copy for edge detection
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= i_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign o_rise = sync2_q & ~prev_q;

endmodule

// File: rtl/wb_reg_slave.sv
// Wishbone B4 pipelined register slave with programmable wait states;
// also the default responder, erroring on anything it does not decode.
module wb_reg_slave
  import wb_reg_pkg::*;
#(
  parameter logic [29:0] ADDR_BASE   = 30'h0000_0000,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h5742_0001
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_wb_data,
  input  logic        i_button,
  output logic [7:0]  o_leds,
  output logic        o_irq
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        stall_q, stall_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ctrl_q, ctrl_d;
  logic [7:0]  leds_q, leds_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] counter_q, counter_d;
  logic        status_q, status_d;
  logic        irq_q, irq_d;

  logic        accept_s, hit_s, req_we_s, resp_s, commit_s, btn_rise_s;
  logic [29:0] req_addr_s;
  logic [31:0] rd_mux_s;

  sync_edge_detect u_btn_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_button),
    .o_rise  (btn_rise_s)
  );

  // While idle the live bus is decoded; afterwards the latched request is.
  assign accept_s   = i_wb_cyc & i_wb_stb & ~stall_q;
  assign req_addr_s = (state_q == IDLE) ? i_wb_addr : addr_q;
  assign req_we_s   = (state_q == IDLE) ? i_wb_we   : we_q;
  assign hit_s      = (req_addr_s[29:3] == ADDR_BASE[29:3]) && (req_addr_s[2:0] <= REG_STATUS);

  // read data multiplexer
  always_comb begin
    rd_mux_s = 32'd0;
    case (req_addr_s[2:0])
      REG_ID:      rd_mux_s = ID_VALUE;
      REG_CTRL:    rd_mux_s = {31'd0, ctrl_q};
      REG_LEDS:    rd_mux_s = {24'd0, leds_q};
      REG_SCRATCH: rd_mux_s = scratch_q;
      REG_COUNTER: rd_mux_s = counter_q;
      REG_STATUS:  rd_mux_s = {31'd0, status_q};
      default:     rd_mux_s = 32'd0;
    endcase
  end

  // bus FSM next state, request latch and registered response
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          we_d    = i_wb_we;
          addr_d  = i_wb_addr;
          wdata_d = i_wb_data;
          sel_d   = i_wb_sel;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            wcnt_d  = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!i_wb_cyc) begin
          state_d = IDLE;
        end else if (wcnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    resp_s  = (state_d == RESP);
    stall_d = (state_d != IDLE);
    ack_d   = resp_s & hit_s;
    err_d   = resp_s & ~hit_s;
    if (resp_s && hit_s && !req_we_s) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = 32'd0;
    end
  end

  // A write lands at the end of the response cycle unless the master aborted.
  assign commit_s = (state_q == RESP) & i_wb_cyc & we_q & hit_s;

  // register bank update, counter and sticky button flag
  always_comb begin
    ctrl_d    = ctrl_q;
    leds_d    = leds_q;
    scratch_d = scratch_q;
    status_d  = status_q;
    counter_d = counter_q + 32'd1;
    if (commit_s) begin
      case (addr_q[2:0])
        REG_CTRL: begin
          if (sel_q[0]) begin
            ctrl_d = wdata_q[CTRL_IRQ_EN_BIT];
          end else begin
            ctrl_d = ctrl_q;
          end
        end
        REG_LEDS: begin
          if (sel_q[0]) begin
            leds_d = wdata_q[7:0];
          end else begin
            leds_d = leds_q;
          end
        end
        REG_SCRATCH: scratch_d = merge_lanes(scratch_q, wdata_q, sel_q);
        REG_STATUS: begin
          if (sel_q[0] && wdata_q[STATUS_BTN_BIT]) begin
            status_d = 1'b0;
          end else begin
            status_d = status_q;
          end
        end
        default: ctrl_d = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
    // a new edge beats a simultaneous clear
    if (btn_rise_s) begin
      status_d = 1'b1;
    end else begin
      status_d = status_d;
    end
    irq_d = ctrl_d & status_d;
  end

  // state and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      wcnt_q    <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 30'd0;
      wdata_q   <= 32'd0;
      sel_q     <= 4'd0;
      stall_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      ctrl_q    <= 1'b0;
      leds_q    <= 8'd0;
      scratch_q <= 32'd0;
      counter_q <= 32'd0;
      status_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      stall_q   <= stall_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      leds_q    <= leds_d;
      scratch_q <= scratch_d;
      counter_q <= counter_d;
      status_q  <= status_d;
      irq_q     <= irq_d;
    end
  end

  assign o_wb_stall = stall_q;
  assign o_wb_ack   = ack_q;
  assign o_wb_err   = err_q;
  assign o_wb_data  = rdata_q;
  assign o_leds     = leds_q;
  assign o_irq      = irq_q;

endmodule

// File: tb/tb_wb_reg_slave.sv
// Scoreboard bench for wb_reg_slave: one instance with no wait states and
// one with three wait states at a non-zero base address.
module tb_wb_reg_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc0, cyc3, stb, we, button;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        stall0, ack0, err0, irq0, stall3, ack3, err3, irq3;
  logic [31:0] rdat0, rdat3;
  logic [7:0]  leds0, leds3;
  logic [31:0] mcnt;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_reg_slave #(.ADDR_BASE(30'h0000_0000), .WAIT_STATES(0), .ID_VALUE(32'h5742_0001)) u_ws0 (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc0), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_stall(stall0),
    .o_wb_ack(ack0), .o_wb_err(err0), .o_wb_data(rdat0), .i_button(button),
    .o_leds(leds0), .o_irq(irq0));

  wb_reg_slave #(.ADDR_BASE(30'h0000_0040), .WAIT_STATES(3), .ID_VALUE(32'hCAFE_0003)) u_ws3 (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc3), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_stall(stall3),
    .o_wb_ack(ack3), .o_wb_err(err3), .o_wb_data(rdat3), .i_button(button),
    .o_leds(leds3), .o_irq(irq3));

  // reference free-running counter
  always @(posedge clk or posedge rst) begin
    if (rst) mcnt <= 32'd0;
    else     mcnt <= mcnt + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] base_of(input int d);
    return (d == 0) ? 30'h0000_0000 : 30'h0000_0040;
  endfunction

  function automatic logic stall_of(input int d);
    return (d == 0) ? stall0 : stall3;
  endfunction

  function automatic logic resp_of(input int d);
    return (d == 0) ? (ack0 | err0) : (ack3 | err3);
  endfunction

  // response monitors
  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst) begin
      if (ack0 | err0) begin
        if (q0.size() == 0) begin
          check("ws0_spurious_resp", {30'd0, ack0, err0}, 32'd0);
        end else begin
          e = q0.pop_front();
          check("ws0_err", {31'd0, err0}, {31'd0, e.err});
          check("ws0_ack", {31'd0, ack0}, {31'd0, ~e.err});
          check("ws0_data", rdat0, e.data);
        end
      end else if (rdat0 !== 32'd0) begin
        check("ws0_idle_data", rdat0, 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (!rst) begin
      if (ack3 | err3) begin
        if (q3.size() == 0) begin
          check("ws3_spurious_resp", {30'd0, ack3, err3}, 32'd0);
        end else begin
          e = q3.pop_front();
          check("ws3_err", {31'd0, err3}, {31'd0, e.err});
          check("ws3_ack", {31'd0, ack3}, {31'd0, ~e.err});
          check("ws3_data", rdat3, e.data);
        end
      end else if (rdat3 !== 32'd0) begin
        check("ws3_idle_data", rdat3, 32'd0);
      end
    end
  end

  task automatic xfer(input int d, input logic w, input logic [2:0] idx, input logic off_base,
                      input logic [31:0] wd, input logic [3:0] s, input logic eerr,
                      input logic [31:0] edata, input logic is_cnt);
    exp_t e;
    int   lat;
    logic stall_ok;
    @(negedge clk);
    addr  = base_of(d) + {27'd0, idx};
    if (off_base) addr = addr + 30'h0000_0100;
    we    = w;
    wdata = wd;
    sel   = s;
    stb   = 1'b1;
    if (d == 0) cyc0 = 1'b1;
    else        cyc3 = 1'b1;
    check("idle_before_accept", {31'd0, stall_of(d)}, 32'd0);
    e.err  = eerr;
    e.data = is_cnt ? (mcnt + 32'(d)) : edata;
    if (d == 0) q0.push_back(e);
    else        q3.push_back(e);
    @(posedge clk); #1;
    stb = 1'b0;
    lat = 1;
    stall_ok = 1'b1;
    while (!resp_of(d) && lat < 40) begin
      if (!stall_of(d)) stall_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("resp_latency", 32'(lat), 32'(1 + d));
    check("stall_held", {31'd0, stall_of(d) & stall_ok}, 32'd1);
    @(posedge clk); #1;
    cyc0 = 1'b0;
    cyc3 = 1'b0;
    check("stall_release", {31'd0, stall_of(d)}, 32'd0);
    check("single_cycle_resp", {31'd0, resp_of(d)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
    addr = 30'd0; wdata = 32'd0; sel = 4'd0; button = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stall", {30'd0, stall0, stall3}, 32'd0);
    check("rst_resp", {28'd0, ack0, err0, ack3, err3}, 32'd0);
    check("rst_data", rdat0 | rdat3, 32'd0);
    check("rst_leds_irq", {14'd0, leds0, leds3, irq0, irq3}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ID reads, scratch byte lanes, sel=0 write
    xfer(0, 1'b0, 3'd0, 1'b0, 32'd0, 4'hF, 1'b0, 32'h5742_0001, 1'b0);
    xfer(3, 1'b0, 3'd0, 1'b0, 32'd0, 4'hF, 1'b0, 32'hCAFE_0003, 1'b0);
    xfer(0, 1'b1, 3'd3, 1'b0, 32'hA5A5_1234, 4'b0101, 1'b0, 32'd0, 1'b0);
    xfer(0, 1'b0, 3'd3, 1'b0, 32'd0, 4'hF, 1'b0, 32'h00A5_0034, 1'b0);
    xfer(0, 1'b1, 3'd3, 1'b0, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'd0, 1'b0);
    xfer(0, 1'b0, 3'd3, 1'b0, 32'd0, 4'b0000, 1'b0, 32'h00A5_0034, 1'b0);

    // wait-state write to LEDS, RO write to ID
    xfer(3, 1'b1, 3'd2, 1'b0, 32'h0000_003C, 4'b0001, 1'b0, 32'd0, 1'b0);
    check("leds3_after_write", {24'd0, leds3}, 32'h0000_003C);
    check("leds0_untouched", {24'd0, leds0}, 32'd0);
    xfer(3, 1'b1, 3'd0, 1'b0, 32'h1111_2222, 4'hF, 1'b0, 32'd0, 1'b0);
    xfer(3, 1'b0, 3'd0, 1'b0, 32'd0, 4'hF, 1'b0, 32'hCAFE_0003, 1'b0);

    // error responses without side effects
    xfer(0, 1'b0, 3'd6, 1'b0, 32'd0, 4'hF, 1'b1, 32'd0, 1'b0);
    xfer(0, 1'b1, 3'd7, 1'b0, 32'h1234_5678, 4'hF, 1'b1, 32'd0, 1'b0);
    xfer(0, 1'b1, 3'd3, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'd0, 1'b0);
    xfer(0, 1'b0, 3'd3, 1'b0, 32'd0, 4'hF, 1'b0, 32'h00A5_0034, 1'b0);
    xfer(3, 1'b0, 3'd6, 1'b0, 32'd0, 4'hF, 1'b1, 32'd0, 1'b0);
    xfer(3, 1'b1, 3'd2, 1'b1, 32'h0000_00FF, 4'hF, 1'b1, 32'd0, 1'b0);
    check("leds3_after_err", {24'd0, leds3}, 32'h0000_003C);

    // counter value at the sample cycle
    xfer(0, 1'b0, 3'd4, 1'b0, 32'd0, 4'hF, 1'b0, 32'd0, 1'b1);
    xfer(3, 1'b0, 3'd4, 1'b0, 32'd0, 4'hF, 1'b0, 32'd0, 1'b1);

    // button edge, irq enable, set-wins W1C, clean W1C
    @(posedge clk); #1; button = 1'b1;
    repeat (4) @(posedge clk);
    #1; button = 1'b0;
    repeat (4) @(posedge clk);
    xfer(0, 1'b0, 3'd5, 1'b0, 32'd0, 4'hF, 1'b0, 32'd1, 1'b0);
    xfer(3, 1'b0, 3'd5, 1'b0, 32'd0, 4'hF, 1'b0, 32'd1, 1'b0);
    check("irq0_before_enable", {31'd0, irq0}, 32'd0);
    xfer(0, 1'b1, 3'd1, 1'b0, 32'd1, 4'b0001, 1'b0, 32'd0, 1'b0);
    check("irq0_enabled", {31'd0, irq0}, 32'd1);
    check("irq3_not_enabled", {31'd0, irq3}, 32'd0);
    @(posedge clk); #1; button = 1'b1;
    @(posedge clk);
    xfer(0, 1'b1, 3'd5, 1'b0, 32'd1, 4'b0001, 1'b0, 32'd0, 1'b0);
    check("irq0_set_wins", {31'd0, irq0}, 32'd1);
    xfer(0, 1'b0, 3'd5, 1'b0, 32'd0, 4'hF, 1'b0, 32'd1, 1'b0);
    button = 1'b0;
    repeat (4) @(posedge clk);
    xfer(0, 1'b1, 3'd5, 1'b0, 32'd1, 4'b0001, 1'b0, 32'd0, 1'b0);
    check("irq0_cleared", {31'd0, irq0}, 32'd0);
    xfer(0, 1'b0, 3'd5, 1'b0, 32'd0, 4'hF, 1'b0, 32'd0, 1'b0);

    // abort during WAIT discards the write
    @(negedge clk);
    addr = base_of(3) + 30'd3; we = 1'b1; wdata = 32'h1234_5678; sel = 4'hF;
    stb = 1'b1; cyc3 = 1'b1;
    @(posedge clk); #1; stb = 1'b0;
    @(posedge clk); #1; cyc3 = 1'b0;
    @(posedge clk); #1;
    check("abort_stall_low", {31'd0, stall3}, 32'd0);
    repeat (6) @(posedge clk);
    xfer(3, 1'b0, 3'd3, 1'b0, 32'd0, 4'hF, 1'b0, 32'd0, 1'b0);

    // reset in the middle of a wait-state transaction
    @(negedge clk);
    addr = base_of(3); we = 1'b0; sel = 4'hF; stb = 1'b1; cyc3 = 1'b1;
    @(posedge clk); #1; stb = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    #1;
    check("midrst_outputs", {29'd0, stall3, ack3, err3}, 32'd0);
    check("midrst_data", rdat3, 32'd0);
    check("midrst_leds", {24'd0, leds3}, 32'd0);
    cyc3 = 1'b0;
    q3.delete();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    xfer(3, 1'b0, 3'd2, 1'b0, 32'd0, 4'hF, 1'b0, 32'd0, 1'b0);
    xfer(0, 1'b0, 3'd1, 1'b0, 32'd0, 4'hF, 1'b0, 32'd0, 1'b0);

    repeat (3) @(posedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
